// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state encoding and width helpers for UART-side blocks
package uart_pkg;
  typedef logic [0:0] state_t;
  localparam state_t IDLE = 1'b0;
  localparam state_t XFER = 1'b1;
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_TIMEOUT = 1024;
  function automatic int cw(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester byte streams plus the shared TX byte stream toward uart_fifo
interface uart_tx_arbiter_if import uart_pkg::*; #(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W = DEF_DATA_W
);
  logic [NUM_REQ*DATA_W-1:0] s_data;
  logic [NUM_REQ-1:0] s_valid;
  logic [NUM_REQ-1:0] s_last;
  logic [NUM_REQ-1:0] s_ready;
  logic [DATA_W-1:0] m_data;
  logic m_valid;
  logic m_ready;
  modport slave (input s_data, s_valid, s_last, m_ready, output s_ready, m_data, m_valid);
  modport master (output s_data, s_valid, s_last, m_ready, input s_ready, m_data, m_valid);
endinterface

// File: rtl/rr_pick.sv
// rr_pick: first set request at or after ptr, wrapping modulo N
module rr_pick import uart_pkg::*; #(
  parameter int N = DEF_NUM_REQ,
  parameter int W = cw(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] idx
);
  assign found = |req;
  // scan from farthest to nearest so the nearest hit overwrites
  always_comb begin
    idx = '0;
    for (int k = N - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % N]) idx = W'((int'(ptr) + k) % N);
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-granular round-robin sharing of the UART TX byte stream with stall watchdog
module uart_tx_arbiter import uart_pkg::*; #(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT,
  localparam int GW = cw(NUM_REQ),
  localparam int SW = cw(TIMEOUT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  uart_tx_arbiter_if.slave bus,
  output logic          busy,
  output logic [GW-1:0] grant_id,
  output logic          timeout_err
);
  state_t state;
  logic [GW-1:0] rr_ptr, pick_idx, nxt_ptr;
  logic [SW-1:0] stall_cnt;
  logic pick_found, xfer_st, xfer, done, stall, expire;
  rr_pick #(.N(NUM_REQ), .W(GW)) u_pick (
    .req(bus.s_valid),
    .ptr(rr_ptr),
    .found(pick_found),
    .idx(pick_idx)
  );
  assign xfer_st = state == XFER;
  assign busy = xfer_st;
  assign bus.m_valid = xfer_st & bus.s_valid[grant_id];
  assign bus.m_data = xfer_st ? bus.s_data[grant_id*DATA_W +: DATA_W] : '0;
  // the byte presented while rst is high must not be consumed by its source
  assign bus.s_ready = (xfer_st & ~rst) ? NUM_REQ'(bus.m_ready) << grant_id : '0;
  assign xfer = bus.m_valid & bus.m_ready;
  assign done = xfer & bus.s_last[grant_id];
  assign stall = xfer_st & ~bus.s_valid[grant_id];
  assign expire = (TIMEOUT != 0) && stall && (stall_cnt == SW'(TIMEOUT - 1));
  assign nxt_ptr = (grant_id == GW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant_id <= '0;
      rr_ptr <= '0;
      stall_cnt <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= expire;
      if (!xfer_st) begin
        stall_cnt <= '0;
        if (pick_found) begin
          state <= XFER;
          grant_id <= pick_idx;
        end
      end else if (done || expire) begin
        state <= IDLE;
        rr_ptr <= nxt_ptr;
        stall_cnt <= '0;
      end else if (xfer) begin
        stall_cnt <= '0;
      end else if (stall && stall_cnt != '1) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end
endmodule
